// File: rtl/output_channel_buffer_array_if.sv
// Writeback-to-interconnect bus for the output channel buffer array: enqueue side plus per-channel drain side.
// Latency: none, this is wiring only.
// Backpressure: per-channel deq_ready from the consumer; the enqueue side relies on the producer respecting counts.

`ifndef TIA_NUM_OUTPUT_CHANNELS
`define TIA_NUM_OUTPUT_CHANNELS 4
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 3
`endif
`ifndef TIA_CHANNEL_BUFFER_COUNT_WIDTH
`define TIA_CHANNEL_BUFFER_COUNT_WIDTH 3
`endif

interface output_channel_buffer_array_if #(
    parameter int NUM_CHANNELS = `TIA_NUM_OUTPUT_CHANNELS,
    parameter int WORD_WIDTH   = `TIA_WORD_WIDTH,
    parameter int TAG_WIDTH    = `TIA_TAG_WIDTH,
    parameter int COUNT_WIDTH  = `TIA_CHANNEL_BUFFER_COUNT_WIDTH
);
    // Enqueue side (writeback stage)
    logic                                     enq_valid;
    logic [NUM_CHANNELS-1:0]                  enq_oci;
    logic [WORD_WIDTH-1:0]                    enq_data;
    logic [TAG_WIDTH-1:0]                     enq_tag;

    // Drain side (interconnect), one lane per channel
    logic [NUM_CHANNELS-1:0]                  deq_valid;
    logic [NUM_CHANNELS-1:0]                  deq_ready;
    logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0]  deq_data;
    logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]   deq_tag;

    // Status towards the full-status updater
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] output_channel_counts;
    logic [NUM_CHANNELS-1:0]                  overflow_error;

    // Environment side: drives writes and drain readiness, observes heads and status
    modport master (
        output enq_valid, enq_oci, enq_data, enq_tag, deq_ready,
        input  deq_valid, deq_data, deq_tag, output_channel_counts, overflow_error
    );

    // Buffer side
    modport slave (
        input  enq_valid, enq_oci, enq_data, enq_tag, deq_ready,
        output deq_valid, deq_data, deq_tag, output_channel_counts, overflow_error
    );
endinterface

// File: rtl/output_channel_buffer_array.sv
// Per-channel output FIFO array with OCI-mask multicast writes; optional sticky overflow via TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN.
// Latency: 1 cycle from enqueue edge to deq_valid/count; no same-cycle enqueue-to-dequeue bypass.
// Backpressure: per-channel deq_ready drains heads; a full channel accepts a write only if it dequeues that cycle.

`ifndef TIA_NUM_OUTPUT_CHANNELS
`define TIA_NUM_OUTPUT_CHANNELS 4
`endif
`ifndef TIA_CHANNEL_BUFFER_FIFO_DEPTH
`define TIA_CHANNEL_BUFFER_FIFO_DEPTH 4
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 3
`endif
`ifndef TIA_CHANNEL_BUFFER_COUNT_WIDTH
`define TIA_CHANNEL_BUFFER_COUNT_WIDTH 3
`endif

// Generic circular FIFO with non-power-of-two depth and a registered occupancy count.
// Latency: 1 cycle write-to-read; head is read combinationally from storage.
// Backpressure: deq_rdy pops the head; when full, a push is taken only alongside a same-cycle pop, else flagged on enq_rej.
module output_channel_fifo #(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enq_vld,
    input  logic [DATA_WIDTH-1:0]  enq_dat,
    output logic                   enq_rej,
    output logic                   deq_vld,
    input  logic                   deq_rdy,
    output logic [DATA_WIDTH-1:0]  deq_dat,
    output logic [COUNT_WIDTH-1:0] count
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic                  deq_fire;
    logic                  enq_fire;
    logic                  can_accept;

    // Pointers wrap explicitly at DEPTH-1 so any depth works, not just powers of two
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // Head is valid only from stored state, so a write never shows up in its own cycle
    assign deq_vld    = (count != '0);
    assign deq_dat    = mem[rd_ptr];
    assign deq_fire   = deq_vld & deq_rdy;
    // A full channel frees a slot when its head leaves in the same cycle
    assign can_accept = (count < FULL_COUNT) | deq_fire;
    assign enq_fire   = enq_vld & can_accept;
    assign enq_rej    = enq_vld & ~can_accept;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= enq_dat;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + COUNT_ONE;
            end else if (deq_fire && !enq_fire) begin
                count <= count - COUNT_ONE;
            end
        end
    end
endmodule

// Output channel buffer array top: one FIFO per channel, multicast fan-out of each write by OCI mask.
// Latency: 1 cycle enqueue to visibility on deq_valid and output_channel_counts.
// Backpressure: each channel drains on its own deq_ready; rejected writes are dropped per channel without blocking others.
module output_channel_buffer_array #(
    parameter int NUM_CHANNELS = `TIA_NUM_OUTPUT_CHANNELS,
    parameter int DEPTH        = `TIA_CHANNEL_BUFFER_FIFO_DEPTH,
    parameter int WORD_WIDTH   = `TIA_WORD_WIDTH,
    parameter int TAG_WIDTH    = `TIA_TAG_WIDTH,
    parameter int COUNT_WIDTH  = `TIA_CHANNEL_BUFFER_COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output_channel_buffer_array_if.slave bus
);
    // Tag and payload travel together as one stored entry
    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    localparam int ENTRY_WIDTH = $bits(entry_t);

    entry_t                  enq_entry;
    entry_t                  head     [NUM_CHANNELS];
    logic                    head_vld [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]  count    [NUM_CHANNELS];
    logic                    rej      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rej_vec;

    assign enq_entry = '{tag: bus.enq_tag, data: bus.enq_data};

    // Each selected channel decides on its own whether the write fits
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        output_channel_fifo #(
            .DEPTH       (DEPTH),
            .DATA_WIDTH  (ENTRY_WIDTH),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .enq_vld (bus.enq_valid & bus.enq_oci[i]),
            .enq_dat (enq_entry),
            .enq_rej (rej[i]),
            .deq_vld (head_vld[i]),
            .deq_rdy (bus.deq_ready[i]),
            .deq_dat (head[i]),
            .count   (count[i])
        );
    end

    // Gather per-channel heads and counts onto the bus lanes
    always_comb begin
        bus.deq_valid             = '0;
        bus.deq_data              = '0;
        bus.deq_tag               = '0;
        bus.output_channel_counts = '0;
        rej_vec                   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            bus.deq_valid[i]             = head_vld[i];
            bus.deq_data[i]              = head[i].data;
            bus.deq_tag[i]               = head[i].tag;
            bus.output_channel_counts[i] = count[i];
            rej_vec[i]                   = rej[i];
        end
    end

`ifdef TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN
    logic [NUM_CHANNELS-1:0] overflow_q;

    // A dropped write means upstream ignored the counts; latch it until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_q | rej_vec;
        end
    end

    assign bus.overflow_error = overflow_q;

    // Simulation-only alert for the upstream contract being broken
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) rej_vec == '0)
        else $warning("output_channel_buffer_array: write dropped on full channel mask %b", rej_vec);
`else
    // Rejected writes are still dropped by the FIFOs; no flag is kept
    logic unused_rej;
    assign unused_rej         = |rej_vec;
    assign bus.overflow_error = '0;
`endif
endmodule

// File: tb/tb_output_channel_buffer_array.sv
module tb_output_channel_buffer_array;
    localparam int N  = 4;
    localparam int D  = 5;
    localparam int W  = 16;
    localparam int T  = 3;
    localparam int CW = 3;
`ifdef TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    output_channel_buffer_array_if #(.NUM_CHANNELS(N), .WORD_WIDTH(W), .TAG_WIDTH(T), .COUNT_WIDTH(CW)) bus ();

    output_channel_buffer_array #(
        .NUM_CHANNELS(N), .DEPTH(D), .WORD_WIDTH(W), .TAG_WIDTH(T), .COUNT_WIDTH(CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic                   ev;
        logic [N-1:0]           oci;
        logic [W-1:0]           data;
        logic [T-1:0]           tag;
        logic [N-1:0]           rdy;
        logic [N-1:0][CW-1:0]   cnt;
        logic                   hchk;
        logic [1:0]             hch;
        logic [W-1:0]           hdata;
        logic [T-1:0]           htag;
        logic [N-1:0]           ovf;
    } vec_t;

    vec_t         tbl[$];
    logic [N-1:0] ovf_run = '0;

    // Reference model: one queue of {tag,data} per channel plus sticky flags
    logic [W+T-1:0] mq [N][$];
    logic [N-1:0]   ovf_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [N-1:0] oci, input logic [W-1:0] d,
                         input logic [T-1:0] t, input logic [N-1:0] rdy);
        bus.enq_valid = ev;
        bus.enq_oci   = oci;
        bus.enq_data  = d;
        bus.enq_tag   = t;
        bus.deq_ready = rdy;
    endtask

    // Expected values are those seen in the row's cycle, before its inputs take effect at the next edge
    task automatic add(input logic ev, input logic [N-1:0] oci, input int d, input int t, input logic [N-1:0] rdy,
                       input int c0, input int c1, input int c2, input int c3,
                       input int hch, input int hd, input int ht);
        vec_t v;
        v.ev = ev; v.oci = oci; v.data = W'(d); v.tag = T'(t); v.rdy = rdy;
        v.cnt[0] = CW'(c0); v.cnt[1] = CW'(c1); v.cnt[2] = CW'(c2); v.cnt[3] = CW'(c3);
        v.hchk = (hch >= 0); v.hch = 2'(hch); v.hdata = W'(hd); v.htag = T'(ht);
        v.ovf = ovf_run;
        tbl.push_back(v);
    endtask

    task automatic check_all_empty(input string tagname);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("%s cnt%0d", tagname, c), 32'(bus.output_channel_counts[c]), 0);
            chk($sformatf("%s vld%0d", tagname, c), 32'(bus.deq_valid[c]), 0);
            chk($sformatf("%s ovf%0d", tagname, c), 32'(bus.overflow_error[c]), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, '0, '0, '0);

        // Directed table: single write, multicast fill with wrap, full+deq, overflow, partial multicast
        add(1, 4'b0001, 'h1234, 2, 4'b0000, 0, 0, 0, 0, -1, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0001, 1, 0, 0, 0, 0, 'h1234, 2);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, -1, 0, 0);
        for (int k = 1; k <= D; k++) add(1, 4'b0101, k, k, 4'b0000, k-1, 0, k-1, 0, -1, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, D, 0, D, 0, 0, 1, 1);
        for (int k = 1; k <= D; k++) add(0, 4'b0000, 0, 0, 4'b0101, D-k+1, 0, D-k+1, 0, (k % 2 == 1) ? 0 : 2, k, k);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, -1, 0, 0);
        for (int k = 0; k < D; k++) add(1, 4'b0010, 'h10 + k, 0, 4'b0000, 0, k, 0, 0, -1, 0, 0);
        add(1, 4'b0010, 'hAA, 1, 4'b0010, 0, D, 0, 0, 1, 'h10, 0);
        for (int k = 1; k <= D; k++) add(0, 4'b0000, 0, 0, 4'b0010, 0, D-k+1, 0, 0, 1, (k < D) ? 'h10 + k : 'hAA, (k < D) ? 0 : 1);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, -1, 0, 0);
        for (int k = 0; k < D; k++) add(1, 4'b0010, 'h20 + k, 0, 4'b0000, 0, k, 0, 0, -1, 0, 0);
        add(1, 4'b0010, 'hBB, 5, 4'b0000, 0, D, 0, 0, 1, 'h20, 0);
        ovf_run[1] = OVF_ON;
        add(0, 4'b0000, 0, 0, 4'b0000, 0, D, 0, 0, 1, 'h20, 0);
        for (int k = 0; k < D; k++) add(0, 4'b0000, 0, 0, 4'b0010, 0, D-k, 0, 0, 1, 'h20 + k, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, -1, 0, 0);
        for (int k = 0; k < D; k++) add(1, 4'b0001, 'h30 + k, 0, 4'b0000, k, 0, 0, 0, -1, 0, 0);
        add(1, 4'b0011, 'h77, 3, 4'b0000, D, 0, 0, 0, -1, 0, 0);
        ovf_run[0] = OVF_ON;
        add(0, 4'b0000, 0, 0, 4'b0000, D, 1, 0, 0, 1, 'h77, 3);
        add(0, 4'b0000, 0, 0, 4'b0010, D, 1, 0, 0, 0, 'h30, 0);
        for (int k = 0; k < D; k++) add(0, 4'b0000, 0, 0, 4'b0001, D-k, 0, 0, 0, 0, 'h30 + k, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, -1, 0, 0);

        // Reset state, checked while held and after release
        repeat (2) @(posedge clk);
        #1;
        check_all_empty("in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_empty("post_reset");

        for (int r = 0; r < tbl.size(); r++) begin
            vec_t v;
            v = tbl[r];
            @(posedge clk);
            #1;
            drive(v.ev, v.oci, v.data, v.tag, v.rdy);
            #1;
            for (int c = 0; c < N; c++) begin
                chk($sformatf("row%0d cnt%0d", r, c), 32'(bus.output_channel_counts[c]), 32'(v.cnt[c]));
                chk($sformatf("row%0d vld%0d", r, c), 32'(bus.deq_valid[c]), 32'(v.cnt[c] != '0));
                chk($sformatf("row%0d ovf%0d", r, c), 32'(bus.overflow_error[c]), 32'(v.ovf[c]));
            end
            if (v.hchk) begin
                chk($sformatf("row%0d data%0d", r, v.hch), 32'(bus.deq_data[v.hch]), 32'(v.hdata));
                chk($sformatf("row%0d tag%0d", r, v.hch), 32'(bus.deq_tag[v.hch]), 32'(v.htag));
            end
        end

        // Asynchronous reset mid-traffic: fill channel 3 with three entries
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 4'b1000, W'(16'h40 + k), 3'd0, 4'b0000);
        end
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0, '0);
        #1;
        chk("pre_arst cnt3", 32'(bus.output_channel_counts[3]), 3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst cnt3", 32'(bus.output_channel_counts[3]), 0);
        chk("arst vld", 32'(bus.deq_valid), 0);
        chk("arst ovf", 32'(bus.overflow_error), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 4'b1000, 16'h0099, 3'd4, 4'b0000);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0, 4'b1000);
        #1;
        chk("after_arst cnt3", 32'(bus.output_channel_counts[3]), 1);
        chk("after_arst vld", 32'(bus.deq_valid), 32'(4'b1000));
        chk("after_arst data3", 32'(bus.deq_data[3]), 'h99);
        chk("after_arst tag3", 32'(bus.deq_tag[3]), 4);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0, '0);
        #1;
        chk("after_arst drain cnt3", 32'(bus.output_channel_counts[3]), 0);

        // Randomized traffic against the queue model, from a fresh reset
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < N; c++) mq[c].delete();
        ovf_m = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic         ev;
            logic [N-1:0] oci;
            logic [N-1:0] rdy;
            logic [W-1:0] d;
            logic [T-1:0] t;
            @(posedge clk);
            #1;
            ev  = ($urandom_range(0, 3) != 0);
            oci = N'($urandom);
            d   = W'($urandom);
            t   = T'($urandom);
            for (int c = 0; c < N; c++)
                rdy[c] = (cyc < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            drive(ev, oci, d, t, rdy);
            #1;
            for (int c = 0; c < N; c++) begin
                chk($sformatf("rnd%0d cnt%0d", cyc, c), 32'(bus.output_channel_counts[c]), mq[c].size());
                chk($sformatf("rnd%0d vld%0d", cyc, c), 32'(bus.deq_valid[c]), 32'(mq[c].size() != 0));
                chk($sformatf("rnd%0d ovf%0d", cyc, c), 32'(bus.overflow_error[c]), 32'(ovf_m[c]));
                if (mq[c].size() != 0)
                    chk($sformatf("rnd%0d head%0d", cyc, c), 32'({bus.deq_tag[c], bus.deq_data[c]}), 32'(mq[c][0]));
            end
            // Advance the model to the state after the coming edge
            for (int c = 0; c < N; c++) begin
                bit pop;
                pop = (mq[c].size() != 0) && rdy[c];
                if (pop) void'(mq[c].pop_front());
                if (ev && oci[c]) begin
                    if (mq[c].size() < D) mq[c].push_back({t, d});
                    else if (OVF_ON) ovf_m[c] = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_channel_buffer_array.md
# output_channel_buffer_array

Per-channel output FIFO array between the PE writeback stage and the interconnect. It is the producer of the `output_channel_counts` that the full-status updater consumes. It accepts multicast writes selected by an output-channel-index (OCI) mask and drains each channel independently through a valid/ready handshake. It also reports registered occupancy counts and a sticky overflow indication.

## Interface
- `NUM_CHANNELS`, default `TIA_NUM_OUTPUT_CHANNELS`: number of output channels.
- `DEPTH`, default `TIA_CHANNEL_BUFFER_FIFO_DEPTH`: entries per channel, ≥2, need not be a power of two.
- `WORD_WIDTH`, default `TIA_WORD_WIDTH`: data width.
- `TAG_WIDTH`, default `TIA_TAG_WIDTH`: tag width.
- `COUNT_WIDTH`, default `TIA_CHANNEL_BUFFER_COUNT_WIDTH`: count width; must hold `DEPTH`.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enq_valid`  in  1  writeback presents a result this cycle.
- `enq_oci`  in  NUM_CHANNELS  destination mask; multiple bits = multicast.
- `enq_data`  in  WORD_WIDTH  payload.
- `enq_tag`  in  TAG_WIDTH  tag.
- `deq_valid`  out  NUM_CHANNELS  channel i head is valid.
- `deq_ready`  in  NUM_CHANNELS  consumer of channel i accepts head.
- `deq_data`  out  WORD_WIDTH × NUM_CHANNELS  head data per channel.
- `deq_tag`  out  TAG_WIDTH × NUM_CHANNELS  head tag per channel.
- `output_channel_counts`  out  COUNT_WIDTH × NUM_CHANNELS  registered occupancy.
- `overflow_error`  out  NUM_CHANNELS  sticky per-channel overflow flag.

## Operation
- Each channel is a circular buffer with a read pointer, a write pointer, and a count register.
- Pointers increment modulo `DEPTH`. They wrap from `DEPTH-1` to 0 with no power-of-two assumption.
- Enqueue on channel i occurs when `enq_valid & enq_oci[i]` is set and the channel can accept.
  - The channel can accept when `count < DEPTH`, or when `count == DEPTH` and a dequeue fires the same cycle.
- Dequeue on channel i fires when `deq_valid[i] & deq_ready[i]`.
- `deq_valid[i] = (count[i] != 0)`. `deq_data`/`deq_tag` show the head entry.
  - When the channel is empty, head outputs are don't-care; the bench must not check them.
- Count update per cycle: +1 on enqueue only, −1 on dequeue only, unchanged on both or neither.
- Multicast: each selected channel decides independently. A full channel rejecting the write does not block other selected channels.
- Rejected write (selected channel full, no same-cycle dequeue): data is discarded and channel state is unchanged. Overflow handling follows Configuration.
- `enq_oci == 0` with `enq_valid` set is a no-op. `enq_oci` bits are ignored when `enq_valid` is 0.
- Upstream contract: the full-status updater guarantees no overflow in normal operation. Overflow indicates an upstream bug.

## Timing
- Reset (async assert, sync release): all pointers 0, counts 0, `deq_valid` 0, `overflow_error` 0.
  - Buffered contents are lost on reset, including reset asserted mid-traffic.
- Enqueue-to-visibility latency is 1 cycle. An entry written at edge N appears in `output_channel_counts` and can raise `deq_valid` after edge N.
- There is no same-cycle enqueue-to-dequeue bypass. An empty channel never asserts `deq_valid` in the cycle of the write.
- Dequeue is combinational on `deq_ready`. Head advances and count drops after the edge.
- Full and simultaneous enq+deq: count stays `DEPTH`, both pointers advance, order preserved.
- Empty and `deq_ready` high: no effect.
- Occupancy stays in 0..DEPTH under all stimuli.
- Throughput: one enqueue and one dequeue per channel per cycle.

## Configuration
- `TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN` defined:
  - A rejected write sets `overflow_error[i]` at the next edge.
  - The flag holds until `reset_n` is asserted.
  - A simulation-only assertion also fires.
- Not defined:
  - `overflow_error` is tied to 0 and no checking logic is present.
  - Rejected writes are still silently discarded, so datapath behaviour is identical.

## Test plan
- Reset, then single write to channel 0 (data 0x1234, tag 2):
  - Count 0 in the write cycle; count 1 and `deq_valid[0]` with head 0x1234/tag 2 one cycle later.
  - With `deq_ready` high, count returns to 0 the cycle after.
- Multicast `enq_oci = 0b0101` with `DEPTH` consecutive writes 1..DEPTH and no `deq_ready`:
  - Channels 0 and 2 reach count `DEPTH`; other channels stay 0.
  - Draining yields 1..DEPTH in order, exercising pointer wrap.
- Channel 1 full, write 0xAA with `deq_ready[1]` high in the same cycle:
  - Count stays `DEPTH` and the oldest entry leaves.
  - 0xAA appears last after draining; `overflow_error[1]` stays 0.
- Channel 1 full, write 0xBB with no dequeue:
  - 0xBB never appears and count stays `DEPTH`.
  - `overflow_error[1] = 1` with the macro defined, 0 without.
- Multicast `0b0011` with channel 0 full and channel 1 empty:
  - Channel 1 receives the word; channel 0 is unchanged.
- Fill channel 3 to 3 entries, assert `reset_n` low mid-cycle:
  - Count 0 and `deq_valid` 0 immediately (asynchronous).
  - After release, a new write appears as the sole entry.
